// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory request/response channel plus the
// registered instruction slot handed to decode.
//
// Handshake semantics:
//   imem: a request is accepted on a cycle where imem_req=1 and imem_gnt=1.
//         The single outstanding request completes on the first later cycle
//         with imem_rvalid=1, which carries imem_rdata.
//   slot: decode consumes the slot on a cycle where if_valid=1 and
//         if_ready=1. if_pc/if_instr are stable while if_valid=1 and
//         if_ready=0.
interface pc_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  if_valid;
  logic                  if_ready;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [DATA_WIDTH-1:0] if_instr;

  // Fetch controller side
  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready
  );

  // Memory / decode side
  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: issues one instruction fetch at a time from pc_current,
// captures the response into a single instruction slot for decode, advances
// the PC by 4 on each accepted response, and handles trap/branch redirects,
// dropping responses that belong to a fetch made stale by a redirect.
module pc_fetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc_current,
  output logic                  pc_en,
  output logic [ADDR_WIDTH-1:0] pc_next,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  trap,
  input  logic [ADDR_WIDTH-1:0] trap_vec,
  pc_fetch_ctrl_if.master       bus,
  output logic [1:0]            dbg_state,
  output logic                  dbg_kill
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  kill_q, kill_d;
  logic                  if_valid_q, if_valid_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_raw;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  fetch_req;
  logic                  rsp_accept;
  logic                  slot_consume;

  // Redirect decode: trap wins over branch; targets are forced word-aligned.
  always_comb begin
    redirect     = trap | br_taken;
    redirect_raw = trap ? trap_vec : br_target;
    redirect_pc  = {redirect_raw[ADDR_WIDTH-1:2], 2'b00};
  end

  // Request only when the slot can take the response: empty or draining now.
  always_comb begin
    fetch_req    = (state_q == ST_FETCH) && (!if_valid_q || bus.if_ready);
    rsp_accept   = (state_q == ST_WAIT) && bus.imem_rvalid && !redirect && !kill_q;
    slot_consume = if_valid_q && bus.if_ready;
  end

  // PC update: redirect target, else sequential +4 (wraps naturally).
  // pc_en is gated by rst_n so it is low for the whole reset window.
  always_comb begin
    pc_en   = rst_n && (redirect || rsp_accept);
    pc_next = redirect ? redirect_pc : (pc_current + ADDR_WIDTH'(4));
  end

  // FSM and stale-response (kill) tracking.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
        kill_d  = 1'b0;
      end
      ST_FETCH: begin
        if (fetch_req && bus.imem_gnt) begin
          state_d = ST_WAIT;
          // A redirect in the grant cycle makes this fetch stale already.
          kill_d  = redirect;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          state_d = ST_FETCH;
          kill_d  = 1'b0;
        end else if (redirect) begin
          kill_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_BOOT;
        kill_d  = 1'b0;
      end
    endcase
  end

  // Instruction slot: redirect flush beats capture, capture beats consume.
  always_comb begin
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if (redirect) begin
      if_valid_d = 1'b0;
    end else if (rsp_accept) begin
      if_valid_d = 1'b1;
      if_pc_d    = pc_current;
      if_instr_d = bus.imem_rdata;
    end else if (slot_consume) begin
      if_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  // Output drive onto the bus and debug taps.
  always_comb begin
    bus.imem_req  = fetch_req;
    bus.imem_addr = pc_current;
    bus.if_valid  = if_valid_q;
    bus.if_pc     = if_pc_q;
    bus.if_instr  = if_instr_q;
    dbg_state     = state_q;
    dbg_kill      = kill_q;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all addresses and of the PC.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pc_current  input  ADDR_WIDTH  current PC from the PC register.
REQ-006 pc_en  output  1  PC register load enable.
REQ-007 pc_next  output  ADDR_WIDTH  value the PC register loads when pc_en=1.
REQ-008 br_taken  input  1  branch/jump redirect request, single-cycle pulse.
REQ-009 br_target  input  ADDR_WIDTH  redirect target.
REQ-010 trap  input  1  trap redirect request, single-cycle pulse.
REQ-011 trap_vec  input  ADDR_WIDTH  trap handler address.
REQ-012 imem_req  output  1  instruction fetch request.
REQ-013 imem_addr  output  ADDR_WIDTH  fetch address; equals pc_current.
REQ-014 imem_gnt  input  1  request accepted this cycle.
REQ-015 imem_rvalid  input  1  fetch response valid.
REQ-016 imem_rdata  input  DATA_WIDTH  fetch response data.
REQ-017 if_valid  output  1  registered instruction slot holds a valid instruction.
REQ-018 if_ready  input  1  decode consumes the slot when if_valid=1 and if_ready=1.
REQ-019 if_pc  output  ADDR_WIDTH  PC of the slot instruction.
REQ-020 if_instr  output  DATA_WIDTH  slot instruction.

Function
REQ-021 FSM states are BOOT, FETCH, and WAIT; BOOT always transitions to FETCH on the next cycle.
REQ-022 In FETCH, imem_req=1 only when if_valid=0 or if_ready=1; imem_req=1 with imem_gnt=1 transitions the FSM to WAIT.
REQ-023 In WAIT, imem_req=0; imem_rvalid=1 transitions the FSM to FETCH; no more than one request is ever outstanding.
REQ-024 An accepted response (WAIT, imem_rvalid=1, no redirect, kill=0) loads if_instr=imem_rdata and if_pc=pc_current, sets if_valid=1, and asserts pc_en=1 with pc_next=pc_current+4 in the same cycle.
REQ-025 PC increment wraps modulo 2^ADDR_WIDTH (0xFFFFFFFC+4 -> 0x00000000).
REQ-026 Redirect priority is trap > br_taken > sequential; when trap and br_taken are both high, pc_next=trap_vec.
REQ-027 On redirect, pc_en=1 and pc_next=target with bits[1:0] forced to 0, in the same cycle as the request.
REQ-028 On redirect, if_valid clears on the next edge, overriding any same-cycle response capture.
REQ-029 A redirect in WAIT without imem_rvalid sets kill; the next response is dropped (no slot load, no pc_en), kill clears, and the FSM goes to FETCH.
REQ-030 Redirect coincident with imem_rvalid in WAIT drops that response; the FSM goes to FETCH and kill stays 0.
REQ-031 Redirect in FETCH coincident with imem_gnt: the FSM enters WAIT with kill=1.
REQ-032 The slot is consumed when if_valid=1 and if_ready=1; if_valid clears unless a new response loads in the same cycle.
REQ-033 pc_en=0 in every cycle with neither an accepted response nor a redirect.
REQ-034 if_pc and if_instr hold their values while if_valid=1 and if_ready=0.

Reset
REQ-035 While rst_n=0: FSM=BOOT, kill=0, if_valid=0, if_pc=0, if_instr=0, pc_en=0, imem_req=0.
REQ-036 Reset asserted mid-WAIT discards the outstanding fetch; a response arriving after release is ignored because the FSM is not in WAIT.

Verification
REQ-037 Sequential fetch: pc_current=0x0, 1-cycle gnt, rvalid next cycle, if_ready=1 -> if_pc 0x0,0x4,0x8 with one pc_en pulse per response.
REQ-038 Backpressure: if_ready=0 with the slot full -> imem_req stays 0 and if_pc/if_instr stay stable; if_ready=1 -> the request resumes that cycle.
REQ-039 Redirect in WAIT: br_taken with br_target=0x103 -> pc_next=0x100, the stale response is dropped, the next fetch uses addr 0x100.
REQ-040 Trap and branch in the same cycle: trap_vec=0x80, br_target=0x200 -> pc_next=0x80, if_valid=0 next cycle.
REQ-041 Wrap: pc_current=0xFFFFFFFC, response accepted -> pc_next=0x00000000.
REQ-042 Reset mid-WAIT: rst_n pulsed low, rvalid after release -> no slot load, FSM goes BOOT -> FETCH.
